// File: rtl/top_k_sequencer_if.sv
// Valid/ready stream bundle with TLAST, shared by the batch input, chain feed
// and result ports of the top-K sequencer.
interface top_k_sequencer_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/top_k_sequencer.sv
// Per-batch top-K engine controller: clears a K-stage top_k_unit chain, streams
// one batch through it, lets it settle, then drains the stage registers in order.
//
// state  | meaning
// CLEAR  | drive the clear word into the chain for K cycles
// STREAM | pass the batch through to the chain, count accepted beats
// SETTLE | wait K cycles for the last value to propagate, then snapshot
// DRAIN  | emit the K snapshot words, stage 0 (maximum) first
module top_k_sequencer #(
  parameter int INTEGER_SIZE = 32,
  parameter int K            = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  top_k_sequencer_if.slave          s_data,
  top_k_sequencer_if.master         chain,
  input  logic [K*INTEGER_SIZE-1:0] reg_tdata,
  top_k_sequencer_if.master         m_result,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      batch_count
);

  localparam int CYC_W = $clog2(K + 1);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {CLEAR, STREAM, SETTLE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [CYC_W-1:0]        cyc;
  logic [IDX_W-1:0]        idx;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic [INTEGER_SIZE-1:0] snap [K];
  logic                    beat;
  logic                    last_word;

  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign beat      = (state == STREAM) && s_data.tvalid && chain.tready;
  assign last_word = (idx == IDX_W'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      cyc         <= CYC_W'(K);
      idx         <= '0;
      cnt         <= '0;
      batch_count <= '0;
      for (int i = 0; i < K; i++) snap[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CLEAR: begin
          cyc <= cyc - 1'b1;
          if (cyc == CYC_W'(1)) begin
            cnt <= '0;
            idx <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            cnt <= cnt_inc;
            if (s_data.tlast) begin
              batch_count <= cnt_inc;
              cyc         <= CYC_W'(K);
            end
          end
        end
        SETTLE: begin
          cyc <= cyc - 1'b1;
          // Last stage has absorbed the final beat by now; freeze the ranking.
          if (cyc == CYC_W'(1)) begin
            for (int i = 0; i < K; i++)
              snap[i] <= reg_tdata[i*INTEGER_SIZE +: INTEGER_SIZE];
          end
        end
        DRAIN: begin
          if (m_result.tready) begin
            if (last_word) begin
              idx <= '0;
              cyc <= CYC_W'(K);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    chain.tdata     = '0;
    chain.tvalid    = 1'b0;
    chain.tlast     = 1'b0;
    s_data.tready   = 1'b0;
    m_result.tdata  = '0;
    m_result.tvalid = 1'b0;
    m_result.tlast  = 1'b0;
    busy            = 1'b1;
    // Outputs are combinational from state, so reset has to force them quiet.
    if (!rst) begin
      case (state)
        CLEAR: begin
          chain.tdata  = {1'b1, {INTEGER_SIZE{1'b0}}};
          chain.tvalid = 1'b1;
          if (cyc == CYC_W'(1)) state_nxt = STREAM;
        end
        STREAM: begin
          busy          = 1'b0;
          chain.tdata   = {1'b0, s_data.tdata};
          chain.tvalid  = s_data.tvalid;
          chain.tlast   = s_data.tlast;
          s_data.tready = chain.tready;
          if (beat && s_data.tlast) state_nxt = SETTLE;
        end
        SETTLE: begin
          if (cyc == CYC_W'(1)) state_nxt = DRAIN;
        end
        DRAIN: begin
          m_result.tvalid = 1'b1;
          m_result.tdata  = snap[idx];
          m_result.tlast  = last_word;
          if (m_result.tready && last_word) state_nxt = CLEAR;
        end
        default: state_nxt = CLEAR;
      endcase
    end
  end

endmodule

// File: doc/top_k_sequencer.md
# top_k_sequencer

Controller that sequences a chain of K `top_k_unit` stages, turning the chain into a reusable per-batch top-K engine. It clears the chain, streams one TLAST-delimited batch of unsigned values into it, waits for the pipeline to settle, and reads out the K stage registers as a descending result stream. It sits between the network RX payload stream and the user result stream, and owns the chain's 33-bit input word, including the clear flag in bit INTEGER_SIZE.

## Interface
- INTEGER_SIZE, 32, data value width
- K, 8, number of chained top_k_unit stages (≥2)
- CNT_WIDTH, 32, width of the batch element counter
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- s_data_TDATA  in  INTEGER_SIZE  batch value, unsigned
- s_data_TVALID  in  1  input valid
- s_data_TLAST  in  1  last value of batch
- s_data_TREADY  out  1  input ready
- chain_TDATA  out  INTEGER_SIZE+1  to stage 0 rx_data_TDATA; MSB = clear flag
- chain_TVALID  out  1  to stage 0 rx_data_TVALID
- chain_TLAST  out  1  to stage 0 rx_data_TLAST
- chain_TREADY  in  1  from chain (downstream accept)
- reg_TDATA  in  K*INTEGER_SIZE  flattened stage registers; stage i at [i*INTEGER_SIZE +: INTEGER_SIZE]
- m_result_TDATA  out  INTEGER_SIZE  result value
- m_result_TVALID  out  1  result valid
- m_result_TLAST  out  1  last of K results
- m_result_TREADY  in  1  result ready
- busy  out  1  high whenever not in STREAM
- batch_count  out  CNT_WIDTH  accepted beats in most recent completed batch

## Operation
- States: CLEAR, STREAM, SETTLE, DRAIN. A down-counter `cyc` (clog2(K+1) bits) and a read index `idx` (0..K-1) support them.
- CLEAR: chain_TDATA = {1'b1, 0}, chain_TVALID = 1, chain_TLAST = 0, s_data_TREADY = 0.
  - Lasts exactly K cycles so the clear word reaches every stage.
  - Then go to STREAM. Clear `idx` and the running count.
- STREAM: combinational pass-through.
  - chain_TDATA = {1'b0, s_data_TDATA}, with MSB forced 0 even when TVALID = 0.
  - chain_TVALID = s_data_TVALID, chain_TLAST = s_data_TLAST, s_data_TREADY = chain_TREADY.
  - Each beat with s_data_TVALID && chain_TREADY increments the running count. The count saturates at all-ones.
  - An accepted beat with TLAST loads batch_count with the final count, including that beat, and goes to SETTLE with cyc = K.
- SETTLE: chain_TVALID = 0, chain_TDATA = 0, s_data_TREADY = 0. Count K cycles, then go to DRAIN.
  - On the SETTLE→DRAIN edge, snapshot all K reg_TDATA words into an internal array.
- DRAIN: m_result_TVALID = 1, m_result_TDATA = snap[idx], m_result_TLAST = (idx == K-1).
  - Stage 0 holds the maximum, so output is descending.
  - Each handshake increments `idx`. The handshake on the last word goes to CLEAR with cyc = K.
- Batches shorter than K yield trailing zeros. Value 0 is indistinguishable from "empty".
- Equal values are kept in separate stages, because a stage only replaces its register on strictly-greater.
- A stall on s_data while in STREAM is legal indefinitely. No timeout.

## Timing
- Reset (async assert) sets these values:
  - state = CLEAR, cyc = K, idx = 0, batch_count = 0.
  - chain_TDATA = 0, chain_TVALID = 0, chain_TLAST = 0, s_data_TREADY = 0.
  - m_result_TVALID = 0, m_result_TDATA = 0, m_result_TLAST = 0, busy = 1.
- After rst deasserts:
  - Cycles 0..K-1: CLEAR outputs are active.
  - Cycle K: STREAM, and s_data_TREADY follows chain_TREADY.
- Input path latency is 0 cycles (combinational). The TLAST acceptance cycle is the last STREAM cycle.
- TLAST to first m_result_TVALID is K+1 cycles.
- DRAIN takes at least K cycles. m_result_TDATA/TLAST stay stable while TVALID && !TREADY.
- Minimum batch turnaround, from TLAST to the next s_data_TREADY, is 3K+1 cycles.
- Reset mid-operation, in any state, aborts the operation:
  - Results already emitted stand. The remaining results are lost.
  - The partial batch is discarded, and the chain is re-cleared before new data is accepted.
- busy = 1 in CLEAR, SETTLE and DRAIN. busy = 0 only in STREAM.

## Test plan
All scenarios use K=4 and a behavioural chain of four top_k_unit stages.
- **Basic batch.** Stimulus: reset, then 5,1,9,3,7 with TLAST on 7.
  - Results: 9,7,5,3 with TLAST on 3. batch_count = 5.
  - First result appears 5 cycles after the TLAST beat.
- **Short batch and duplicates.** Stimulus: 8,4 (TLAST), then 6,6,6 (TLAST).
  - First batch gives 8,4,0,0. Second batch gives 6,6,6,0.
  - The chain is cleared between batches, so no 8 leaks into the second result.
- **Result backpressure.** Stimulus: basic batch with m_result_TREADY low for 3 cycles while word 1 is presented.
  - m_result_TDATA holds 7 with TVALID = 1, and the sequence completes as 9,7,5,3.
- **Chain backpressure.** Stimulus: chain_TREADY low for 4 cycles mid-batch while s_data_TVALID = 1.
  - s_data_TREADY is low for those cycles and the count does not advance.
  - Final batch_count equals the number of handshaked beats.
- **Reset mid-DRAIN.** Stimulus: assert rst after 2 results, deassert, then batch 2,12,1 (TLAST).
  - All outputs go to their reset values immediately.
  - CLEAR runs for 4 cycles, then the results are 12,2,1,0.
- **Clear flag isolation.** Stimulus: input value 0xFFFF_FFFF in STREAM.
  - chain_TDATA[32] = 0 and the value is ranked normally, giving 0xFFFFFFFF as the first result.
